// File: rtl/mem_banked.sv
// mem_banked: segmented memory made of NUM_BANKS single-port banks of BANKSIZE
// words each, mapped flat. The memory is shared by an instruction-fetch port and
// a data port. Reads are registered and take one cycle. When both ports address
// the same bank, the data port wins and the fetch port stalls. Addresses outside
// the mapped range are reported as errors.
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   ireq, ia                   fetch request and word address
//   istall                     combinational: fetch not taken this cycle
//   ivalid, ierr, irdata       registered fetch response (low INSTRUCTIONWIDTH bits)
//   dreq, dwe, da, dwd         data request, write enable, word address, write data
//   dvalid, derr, drdata       registered data response (writes return dwd)
//
// Optional build macro:
//   MEM_CODE_PROTECT_EN        data-port writes to bank 0 are rejected with derr
module mem_banked #(
  parameter int WIDTH            = 32,
  parameter int INSTRUCTIONWIDTH = 24,
  parameter int BANKSIZE         = 128,
  parameter int NUM_BANKS        = 6
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ireq,
  input  logic [WIDTH-1:0]            ia,
  output logic                        istall,
  output logic                        ivalid,
  output logic                        ierr,
  output logic [INSTRUCTIONWIDTH-1:0] irdata,
  input  logic                        dreq,
  input  logic                        dwe,
  input  logic [WIDTH-1:0]            da,
  input  logic [WIDTH-1:0]            dwd,
  output logic                        dvalid,
  output logic                        derr,
  output logic [WIDTH-1:0]            drdata
);

  localparam int OFFW = $clog2(BANKSIZE);
  localparam int BW   = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam logic [WIDTH-1:0] LIMIT = WIDTH'(BANKSIZE * NUM_BANKS);

  logic            d_inr, i_inr;
  logic [BW-1:0]   d_bank, i_bank;
  logic [OFFW-1:0] d_off, i_off;
  logic            d_prot, d_err, d_wr, i_acc;

  logic [WIDTH-1:0]            bank_rd [NUM_BANKS];
  logic [WIDTH-1:0]            d_rd;
  logic [INSTRUCTIONWIDTH-1:0] i_rd;

  // The range check is done on the full address width, so large addresses never
  // alias back into a bank through the bank/offset slices.
  assign d_inr  = (da < LIMIT);
  assign i_inr  = (ia < LIMIT);
  assign d_bank = da[OFFW +: BW];
  assign i_bank = ia[OFFW +: BW];
  assign d_off  = da[OFFW-1:0];
  assign i_off  = ia[OFFW-1:0];

`ifdef MEM_CODE_PROTECT_EN
  assign d_prot = dwe && (d_bank == '0);
`else
  assign d_prot = 1'b0;
`endif

  assign d_err = !d_inr || d_prot;
  assign d_wr  = dreq && dwe && !d_err;

  // Same-bank collisions only matter when both addresses are mapped.
  assign istall = ireq && dreq && d_inr && i_inr && (d_bank == i_bank);
  assign i_acc  = ireq && !istall;

  // Each bank has a single address port. The data port owns the bank when it
  // hits it; otherwise the bank serves the fetch offset.
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [WIDTH-1:0] mem [BANKSIZE];
    logic             d_hit;
    logic [OFFW-1:0]  addr;

    assign d_hit = dreq && d_inr && (d_bank == BW'(b));
    assign addr  = d_hit ? d_off : i_off;

    always_ff @(posedge clk) begin
      if (d_hit && d_wr) mem[addr] <= dwd;
    end

    assign bank_rd[b] = mem[addr];
  end

  always_comb begin
    d_rd = '0;
    i_rd = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (d_bank == BW'(b)) d_rd = bank_rd[b];
      if (i_bank == BW'(b)) i_rd = bank_rd[b][INSTRUCTIONWIDTH-1:0];
    end
  end

  // If nothing is requested, rdata and err keep their previous values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvalid <= 1'b0;
      derr   <= 1'b0;
      drdata <= '0;
      ivalid <= 1'b0;
      ierr   <= 1'b0;
      irdata <= '0;
    end else begin
      dvalid <= dreq;
      if (dreq) begin
        derr   <= d_err;
        drdata <= d_err ? '0 : (dwe ? dwd : d_rd);
      end
      ivalid <= i_acc;
      if (i_acc) begin
        ierr   <= !i_inr;
        irdata <= i_inr ? i_rd : '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_banked.sv
module tb_mem_banked;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        ireq;
  logic [31:0] ia;
  logic        istall, ivalid, ierr;
  logic [23:0] irdata;
  logic        dreq, dwe;
  logic [31:0] da, dwd;
  logic        dvalid, derr;
  logic [31:0] drdata;

  int tests = 0;
  int fails = 0;

  mem_banked dut (
    .clk(clk), .rst_n(rst_n),
    .ireq(ireq), .ia(ia), .istall(istall), .ivalid(ivalid), .ierr(ierr), .irdata(irdata),
    .dreq(dreq), .dwe(dwe), .da(da), .dwd(dwd), .dvalid(dvalid), .derr(derr), .drdata(drdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ireq = 0; ia = 0; dreq = 0; dwe = 0; da = 0; dwd = 0;
  endtask

  task automatic dwrite(input logic [31:0] a, input logic [31:0] d);
    ireq = 0; dreq = 1; dwe = 1; da = a; dwd = d;
    tick();
    idle();
  endtask

  task automatic test_reset();
    rst_n = 0; idle();
    #1;
    tests++; if (dvalid !== 1'b0 || derr !== 1'b0) begin fails++; $display("FAIL reset_d: got dvalid=%b derr=%b want 0 0", dvalid, derr); end
    tests++; if (ivalid !== 1'b0 || ierr !== 1'b0) begin fails++; $display("FAIL reset_i: got ivalid=%b ierr=%b want 0 0", ivalid, ierr); end
    tests++; if (drdata !== 32'h0 || irdata !== 24'h0) begin fails++; $display("FAIL reset_data: got drdata=%h irdata=%h want 0 0", drdata, irdata); end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1;
    tick();
  endtask

  task automatic test_write_read();
    dreq = 1; dwe = 1; da = 300; dwd = 32'hDEADBEEF;
    tick();
    tests++; if (dvalid !== 1'b1 || derr !== 1'b0 || drdata !== 32'hDEADBEEF) begin fails++; $display("FAIL wr_resp: got v=%b e=%b d=%h want 1 0 deadbeef", dvalid, derr, drdata); end
    dwe = 0; dwd = 0;
    tick();
    tests++; if (dvalid !== 1'b1 || derr !== 1'b0 || drdata !== 32'hDEADBEEF) begin fails++; $display("FAIL rd_300: got v=%b e=%b d=%h want 1 0 deadbeef", dvalid, derr, drdata); end
    idle();
  endtask

  task automatic test_parallel();
    dwrite(5, 32'h12ABCDEF);
    dwrite(200, 32'hCAFE0001);
    dwrite(130, 32'h00777777);
    ireq = 1; ia = 5; dreq = 1; dwe = 0; da = 200;
    #1;
    tests++; if (istall !== 1'b0) begin fails++; $display("FAIL par_istall: got %b want 0", istall); end
    tick();
    tests++; if (ivalid !== 1'b1 || ierr !== 1'b0) begin fails++; $display("FAIL par_ivalid: got v=%b e=%b want 1 0", ivalid, ierr); end
`ifndef MEM_CODE_PROTECT_EN
    tests++; if (irdata !== 24'hABCDEF) begin fails++; $display("FAIL par_irdata: got %h want abcdef", irdata); end
`endif
    tests++; if (dvalid !== 1'b1 || drdata !== 32'hCAFE0001) begin fails++; $display("FAIL par_drdata: got v=%b d=%h want 1 cafe0001", dvalid, drdata); end
    idle();
  endtask

  task automatic test_conflict();
    ireq = 1; ia = 130; dreq = 1; dwe = 1; da = 129; dwd = 32'h55;
    #1;
    tests++; if (istall !== 1'b1) begin fails++; $display("FAIL conf_istall: got %b want 1", istall); end
    tick();
    tests++; if (ivalid !== 1'b0 || dvalid !== 1'b1) begin fails++; $display("FAIL conf_valid: got iv=%b dv=%b want 0 1", ivalid, dvalid); end
    dreq = 0; dwe = 0;
    #1;
    tests++; if (istall !== 1'b0) begin fails++; $display("FAIL retry_istall: got %b want 0", istall); end
    tick();
    tests++; if (ivalid !== 1'b1 || irdata !== 24'h777777) begin fails++; $display("FAIL retry_resp: got v=%b d=%h want 1 777777", ivalid, irdata); end
    // same-address write and fetch: fetch stalls, retry sees the new word
    ireq = 1; ia = 130; dreq = 1; dwe = 1; da = 130; dwd = 32'h0A0B0C0D;
    #1;
    tests++; if (istall !== 1'b1) begin fails++; $display("FAIL same_istall: got %b want 1", istall); end
    tick();
    tests++; if (ivalid !== 1'b0) begin fails++; $display("FAIL same_ivalid: got %b want 0", ivalid); end
    dreq = 0; dwe = 0;
    tick();
    tests++; if (ivalid !== 1'b1 || irdata !== 24'h0B0C0D) begin fails++; $display("FAIL same_retry: got v=%b d=%h want 1 0b0c0d", ivalid, irdata); end
    idle();
  endtask

  task automatic test_out_of_range();
    dreq = 1; dwe = 1; da = 767; dwd = 32'h11112222;
    tick();
    tests++; if (dvalid !== 1'b1 || derr !== 1'b0) begin fails++; $display("FAIL last_addr: got v=%b e=%b want 1 0", dvalid, derr); end
    da = 768; dwd = 32'hFFFFFFFF;
    tick();
    tests++; if (dvalid !== 1'b1 || derr !== 1'b1 || drdata !== 32'h0) begin fails++; $display("FAIL oor_write: got v=%b e=%b d=%h want 1 1 0", dvalid, derr, drdata); end
    dwe = 0; da = 767;
    tick();
    tests++; if (derr !== 1'b0 || drdata !== 32'h11112222) begin fails++; $display("FAIL oor_nochange: got e=%b d=%h want 0 11112222", derr, drdata); end
    dreq = 0; ireq = 1; ia = 32'hFFFFFFFF;
    tick();
    tests++; if (ivalid !== 1'b1 || ierr !== 1'b1 || irdata !== 24'h0) begin fails++; $display("FAIL oor_fetch: got v=%b e=%b d=%h want 1 1 0", ivalid, ierr, irdata); end
    // out-of-range fetch whose bank bits match an in-range data access: no stall
    ia = 32'h8000012C; dreq = 1; da = 300;
    #1;
    tests++; if (istall !== 1'b0) begin fails++; $display("FAIL oor_nostall: got %b want 0", istall); end
    tick();
    tests++; if (ierr !== 1'b1 || ivalid !== 1'b1 || drdata !== 32'hDEADBEEF) begin fails++; $display("FAIL oor_par: got iv=%b ie=%b d=%h want 1 1 deadbeef", ivalid, ierr, drdata); end
    idle();
  endtask

  task automatic test_back_to_back();
    ireq = 1; ia = 130; dreq = 1; dwe = 0; da = 300;
    tick();
    tests++; if (dvalid !== 1'b1 || drdata !== 32'hDEADBEEF || ivalid !== 1'b1 || irdata !== 24'h0B0C0D) begin fails++; $display("FAIL b2b_0: got dv=%b d=%h iv=%b i=%h want 1 deadbeef 1 0b0c0d", dvalid, drdata, ivalid, irdata); end
    ia = 5; da = 767;
    tick();
    tests++; if (dvalid !== 1'b1 || drdata !== 32'h11112222 || ivalid !== 1'b1) begin fails++; $display("FAIL b2b_1: got dv=%b d=%h iv=%b want 1 11112222 1", dvalid, drdata, ivalid); end
`ifndef MEM_CODE_PROTECT_EN
    tests++; if (irdata !== 24'hABCDEF) begin fails++; $display("FAIL b2b_1i: got %h want abcdef", irdata); end
`endif
    ia = 130; da = 129;
    #1;
    tests++; if (istall !== 1'b1) begin fails++; $display("FAIL b2b_stall: got %b want 1", istall); end
    tick();
    tests++; if (dvalid !== 1'b1 || drdata !== 32'h55 || ivalid !== 1'b0) begin fails++; $display("FAIL b2b_2: got dv=%b d=%h iv=%b want 1 55 0", dvalid, drdata, ivalid); end
    idle();
    tick();
    tests++; if (dvalid !== 1'b0 || ivalid !== 1'b0 || drdata !== 32'h55 || derr !== 1'b0) begin fails++; $display("FAIL hold: got dv=%b iv=%b d=%h e=%b want 0 0 55 0", dvalid, ivalid, drdata, derr); end
  endtask

  task automatic test_reset_mid();
    dwrite(10, 32'h0000A5A5);
    dreq = 1; dwe = 0; da = 10;
    #2;
    rst_n = 0;
    #1;
    tests++; if (dvalid !== 1'b0 || drdata !== 32'h0) begin fails++; $display("FAIL rst_mid: got v=%b d=%h want 0 0", dvalid, drdata); end
    idle();
    @(posedge clk); #3;
    rst_n = 1;
    tick();
    tests++; if (dvalid !== 1'b0 || ivalid !== 1'b0) begin fails++; $display("FAIL rst_after: got dv=%b iv=%b want 0 0", dvalid, ivalid); end
    dreq = 1; da = 10;
    tick();
    tests++; if (dvalid !== 1'b1) begin fails++; $display("FAIL rst_reread_v: got %b want 1", dvalid); end
`ifndef MEM_CODE_PROTECT_EN
    tests++; if (drdata !== 32'h0000A5A5) begin fails++; $display("FAIL rst_retain: got %h want 0000a5a5", drdata); end
`endif
    idle();
  endtask

  task automatic test_protect();
    dreq = 1; dwe = 1; da = 4; dwd = 32'h1;
    tick();
`ifdef MEM_CODE_PROTECT_EN
    tests++; if (dvalid !== 1'b1 || derr !== 1'b1 || drdata !== 32'h0) begin fails++; $display("FAIL prot_wr: got v=%b e=%b d=%h want 1 1 0", dvalid, derr, drdata); end
    dwe = 0;
    tick();
    tests++; if (derr !== 1'b0 || drdata === 32'h1) begin fails++; $display("FAIL prot_rd: got e=%b d=%h want 0 and not 1", derr, drdata); end
`else
    tests++; if (dvalid !== 1'b1 || derr !== 1'b0 || drdata !== 32'h1) begin fails++; $display("FAIL noprot_wr: got v=%b e=%b d=%h want 1 0 1", dvalid, derr, drdata); end
    dwe = 0;
    tick();
    tests++; if (derr !== 1'b0 || drdata !== 32'h1) begin fails++; $display("FAIL noprot_rd: got e=%b d=%h want 0 1", derr, drdata); end
`endif
    idle();
    tick();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_parallel();
    test_conflict();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid();
    test_protect();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
